// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states and sign helpers.
// The control-unit decoder imports the same op codes.
package mdu_pkg;

    localparam int ITER = 32;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'b000,
        MDU_MULT  = 3'b001,
        MDU_MULTU = 3'b010,
        MDU_DIV   = 3'b011,
        MDU_DIVU  = 3'b100,
        MDU_MTHI  = 3'b101,
        MDU_MTLO  = 3'b110
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } mdu_state_e;

    function automatic logic [31:0] abs32(input logic [31:0] x);
        return x[31] ? (~x + 32'd1) : x;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] x);
        return ~x + 64'd1;
    endfunction

endpackage

// File: rtl/mdu.sv
// Iterative MIPS multiply/divide unit with HI/LO registers. Multiplication and division
// share one 64-bit shift register and one 33-bit adder; signs are fixed up in a final cycle.
module mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = mdu_pkg::ITER
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(ITER);

    mdu_state_e       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [63:0]      acc_reg;      // {P, M} for multiply, {R, Q} for divide
    logic [31:0]      opd_reg;      // multiplicand or divisor magnitude
    logic             is_div_reg;
    logic             neg_q_reg;    // product / quotient must be negated
    logic             neg_r_reg;    // remainder must be negated
    logic [31:0]      hi_reg, lo_reg;
    logic             done_reg;

    logic             is_signed, start_mul, start_div;
    logic [32:0]      add_x, add_y, add_sum;
    logic [63:0]      step_next, prod_fix;
    logic [31:0]      quot_fix, rem_fix;

    assign is_signed = (op == MDU_MULT) || (op == MDU_DIV);
    assign start_mul = (state_reg == IDLE) && ((op == MDU_MULT) || (op == MDU_MULTU));
    assign start_div = (state_reg == IDLE) && ((op == MDU_DIV) || (op == MDU_DIVU)) && (b != '0);

    // Divide feeds the bit shifted out of R back in as the 33rd bit so divisors >= 2^31 work.
    always_comb begin
        add_x   = is_div_reg ? {acc_reg[63], acc_reg[62:31]} : {1'b0, acc_reg[63:32]};
        add_y   = is_div_reg ? ~{1'b0, opd_reg} : (acc_reg[0] ? {1'b0, opd_reg} : 33'd0);
        add_sum = add_x + add_y + {32'd0, is_div_reg};
        if (is_div_reg)
            step_next = add_sum[32] ? {acc_reg[62:0], 1'b0}
                                    : {add_sum[31:0], acc_reg[30:0], 1'b1};
        else
            step_next = {add_sum, acc_reg[31:1]};
    end

    always_comb begin
        prod_fix = neg_q_reg ? neg64(acc_reg) : acc_reg;
        quot_fix = neg_q_reg ? (~acc_reg[31:0] + 32'd1) : acc_reg[31:0];
        rem_fix  = neg_r_reg ? (~acc_reg[63:32] + 32'd1) : acc_reg[63:32];
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_mul || start_div) state_next = CALC;
            CALC:    if (cnt_reg == CNT_W'(ITER - 1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy = (state_reg != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg    <= '0;
            acc_reg    <= '0;
            opd_reg    <= '0;
            is_div_reg <= 1'b0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (op == MDU_MTHI) hi_reg <= a;
                    if (op == MDU_MTLO) lo_reg <= a;
                    if (start_mul || start_div) begin
                        cnt_reg    <= '0;
                        is_div_reg <= start_div;
                        acc_reg    <= {32'd0, start_div ? (is_signed ? abs32(a) : a)
                                                        : (is_signed ? abs32(b) : b)};
                        opd_reg    <= start_div ? (is_signed ? abs32(b) : b)
                                                : (is_signed ? abs32(a) : a);
                        neg_q_reg  <= is_signed && (a[31] ^ b[31]);
                        neg_r_reg  <= is_signed && a[31];
                    end
                end
                CALC: begin
                    acc_reg <= step_next;
                    cnt_reg <= cnt_reg + 1'b1;
                end
                FIX: begin
                    if (is_div_reg) begin
                        hi_reg <= rem_fix;
                        lo_reg <= quot_fix;
                    end else begin
                        hi_reg <= prod_fix[63:32];
                        lo_reg <= prod_fix[31:0];
                    end
                    done_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed corner cases plus random ops against a
// plain-arithmetic HI/LO model.
module tb_mdu;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks   = 0;
    int failures = 0;
    logic [31:0] m_hi = '0, m_lo = '0;

    mdu dut (
        .clk  (clk),
        .rst  (rst),
        .op   (op),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .hi   (hi),
        .lo   (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_md(input logic [2:0] o, input logic [31:0] x,
                                           input logic [31:0] y);
        longint      sx, sy, q, r;
        logic [63:0] tq, tr, res;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        res = '0;
        case (o)
            MDU_MULT:  begin q = sx * sy; res = q; end
            MDU_MULTU: res = {32'd0, x} * {32'd0, y};
            MDU_DIV: begin
                q = sx / sy; r = sx % sy;
                tq = q; tr = r;
                res = {tr[31:0], tq[31:0]};
            end
            MDU_DIVU:  res = {x % y, x / y};
            default:   res = {m_hi, m_lo};
        endcase
        return res;
    endfunction

    // Multiply/divide; inj > 0 issues an MTLO while busy in that cycle, which must be ignored.
    task automatic run_md(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int inj);
        logic [63:0] exp;
        int          cyc;
        bit          zero_div;
        zero_div = ((o == MDU_DIV) || (o == MDU_DIVU)) && (y == 32'd0);
        exp = zero_div ? {m_hi, m_lo} : ref_md(o, x, y);
        @(negedge clk); op = o; a = x; b = y;
        @(posedge clk); #1; op = MDU_NONE; a = $urandom; b = $urandom;
        if (zero_div) begin
            check("divzero_busy", {63'd0, busy}, 64'd0);
            @(posedge clk); #1;
            check("divzero_done", {63'd0, done}, 64'd0);
            check("divzero_hilo", {hi, lo}, exp);
        end else begin
            cyc = 0;
            while (busy && cyc < 100) begin
                cyc++;
                if (cyc == 1) check("hold_hilo", {hi, lo}, {m_hi, m_lo});
                if (cyc == inj) begin op = MDU_MTLO; a = 32'hDEADBEEF; end
                else op = MDU_NONE;
                @(posedge clk); #1;
            end
            op = MDU_NONE;
            check("busy_cycles", 64'(cyc), 64'd33);
            check("done_high", {63'd0, done}, 64'd1);
            check("result_hilo", {hi, lo}, exp);
            m_hi = exp[63:32];
            m_lo = exp[31:0];
            @(posedge clk); #1;
            check("done_pulse", {63'd0, done}, 64'd0);
        end
        $display("op=%0d a=%h b=%h -> hi=%h lo=%h", o, x, y, hi, lo);
    endtask

    // Single-cycle ops: MTHI, MTLO, NONE and reserved.
    task automatic run_mt(input logic [2:0] o, input logic [31:0] x);
        @(negedge clk); op = o; a = x; b = $urandom;
        @(posedge clk); #1; op = MDU_NONE;
        if (o == MDU_MTHI) m_hi = x;
        if (o == MDU_MTLO) m_lo = x;
        check("mt_hilo", {hi, lo}, {m_hi, m_lo});
        check("mt_busy", {63'd0, busy}, 64'd0);
        $display("op=%0d a=%h -> hi=%h lo=%h", o, x, hi, lo);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] rx, ry;
        rst = 1'b1; op = MDU_NONE; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {29'd0, busy, done, 1'b0, hi, lo}, 64'd0);
        @(negedge clk); rst = 1'b0;

        run_md(MDU_MULT, 32'hFFFFFFFF, 32'h00000002, 0);
        check("mult_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFFE);
        run_md(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        check("multu_max", {hi, lo}, 64'hFFFFFFFE_00000001);
        run_md(MDU_DIV, 32'hFFFFFFF9, 32'd2, 0);
        check("div_neg7", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        run_md(MDU_DIVU, 32'hFFFFFFF9, 32'd2, 0);
        check("divu_big", {hi, lo}, 64'h00000001_7FFFFFFC);
        run_md(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 0);
        check("div_wrap", {hi, lo}, 64'h00000000_80000000);
        run_md(MDU_DIVU, 32'd5, 32'd0, 0);
        run_md(MDU_DIVU, 32'hFFFFFFFF, 32'h80000001, 0);
        run_mt(MDU_MTHI, 32'h12345678);
        check("mthi", {32'd0, hi}, 64'h12345678);
        run_mt(MDU_MTLO, 32'hCAFEF00D);
        run_mt(3'b111, 32'h55555555);
        run_md(MDU_MULT, 32'd3, 32'd4, 5);
        check("mtlo_ignored", {hi, lo}, 64'h00000000_0000000C);

        // Asynchronous reset mid-divide
        run_mt(MDU_MTHI, 32'hA5A5A5A5);
        @(negedge clk); op = MDU_DIVU; a = 32'd100; b = 32'd7;
        @(posedge clk); #1; op = MDU_NONE;
        repeat (9) @(posedge clk);
        #3; rst = 1'b1;
        #1;
        check("async_rst", {30'd0, busy, done, hi, lo}, 64'd0);
        m_hi = '0; m_lo = '0;
        @(negedge clk); rst = 1'b0;
        run_md(MDU_DIVU, 32'd100, 32'd7, 0);
        check("divu_after_rst", {hi, lo}, 64'h00000002_0000000E);

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            rx = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
            ry = ($urandom_range(0, 5) == 0) ? 32'd0 :
                 ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            if (ro >= 3'd1 && ro <= 3'd4) run_md(ro, rx, ry, 0);
            else run_mt(ro, rx);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
